mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, meaning the number of 32-bit memory words (power of 2, 2..1024).
REQ-002 The block SHALL have parameter WAIT, default 2, meaning the number of wait cycles between request accept and response (0..15).
REQ-003 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  CPU presents a request.
REQ-006 req_we  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_wdata  input  32  write data.
REQ-009 req_ready  output  1  block can accept a request this cycle.
REQ-010 resp_valid  output  1  one-cycle response strobe.
REQ-011 resp_rdata  output  32  read data, qualified by resp_valid.
REQ-012 resp_err  output  1  misaligned-access flag, qualified by resp_valid.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-014 Accept SHALL occur on a rising edge where state is IDLE and req_valid is 1; req_we, req_addr and req_wdata SHALL be captured at that edge.
REQ-015 On accept, the FSM SHALL go to WAIT with counter = WAIT-1 if WAIT > 0, else directly to RESP.
REQ-016 In WAIT, the FSM SHALL go to RESP at an edge where counter = 0; otherwise it SHALL decrement the counter.
REQ-017 RESP SHALL last exactly one cycle and then return to IDLE; there SHALL be no response back-pressure.
REQ-018 Latency: for an accept at edge N, resp_valid SHALL rise at edge N+WAIT and fall at edge N+WAIT+1.
REQ-019 Max throughput SHALL be one transaction per WAIT+2 cycles.
REQ-020 The word index SHALL be captured addr[log2(DEPTH)+1:2]; upper address bits SHALL be ignored, so addresses wrap modulo DEPTH words.
REQ-021 The memory access SHALL be performed at the edge entering RESP.
REQ-022 An aligned write (addr[1:0] = 0) SHALL store wdata.
REQ-023 An aligned read SHALL load the word into resp_rdata.
REQ-024 For writes, resp_rdata SHALL be 0.
REQ-025 A misaligned access (addr[1:0] != 0) SHALL NOT modify memory and SHALL give resp_rdata = 0 and resp_err = 1.
REQ-026 For aligned accesses, resp_err SHALL be 0.
REQ-027 Requests presented while req_ready = 0 SHALL be ignored and not queued; a held req_valid SHALL be accepted at the first IDLE edge.
REQ-028 A read following a write to the same word SHALL return the new data.
REQ-029 Outside RESP, resp_rdata and resp_err SHALL be 0.

Reset
REQ-030 On reset, the block SHALL immediately set state = IDLE, counter = 0, resp_valid = 0, resp_rdata = 0 and resp_err = 0.
REQ-031 Reset SHALL drive req_ready = 1 once released.
REQ-032 Memory contents SHALL NOT be reset.
REQ-033 Reset during WAIT SHALL abort the transaction: no write, no response.
REQ-034 A write completed before reset SHALL be preserved.

Verification (WAIT=2, DEPTH=64)
REQ-035 The bench SHALL check: write 0x10 <- 0xDEADBEEF accepted at edge N -> resp_valid high between edges N+2 and N+3, rdata 0, err 0, req_ready high after edge N+3.
REQ-036 The bench SHALL check: read 0x10 after that write -> resp_rdata = 0xDEADBEEF, resp_err = 0.
REQ-037 The bench SHALL check wrap-around: write 0x100 <- 0x00001234, then read 0x0 -> 0x00001234.
REQ-038 The bench SHALL check misalignment: read 0x13 -> err 1, rdata 0; write 0x22 <- 0xFFFFFFFF, then read 0x20 -> prior value unchanged.
REQ-039 The bench SHALL check a held request: req_valid held high with changing address during WAIT/RESP -> only the address present at the next IDLE edge is accepted.
REQ-040 The bench SHALL check reset mid-WAIT of a write 0x30 <- 0x5555AAAA -> no resp_valid, word 0x30 unchanged, and word 0x10 still 0xDEADBEEF.

Source files
------------

// File: rtl/mem_responder.sv
// Single-port word memory behind a fixed-latency request/response handshake.
// Misaligned accesses are flagged and leave the memory untouched.
module mem_responder #(
  parameter int DEPTH = 64,
  parameter int WAIT  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic            r_we;
  logic            r_misaligned;
  logic [AW-1:0]   r_idx;
  logic [31:0]     r_wdata;
  logic [31:0]     r_mem [DEPTH];

  logic            w_accept;
  logic            w_enter_resp;
  logic            w_acc_we;
  logic            w_acc_misaligned;
  logic [AW-1:0]   w_acc_idx;
  logic [31:0]     w_acc_wdata;
  logic            w_mem_we;
  logic [31:0]     w_resp_rdata;
  logic            w_unused_addr;

  // With WAIT = 0 the access happens on the accept edge itself, so it must
  // come straight from the request inputs rather than the captured copy.
  assign w_accept         = (r_state == ST_IDLE) && req_valid;
  assign w_enter_resp     = ((r_state == ST_WAIT) && (r_cnt == 4'd0)) ||
                            (w_accept && (WAIT == 0));
  assign w_acc_we         = (r_state == ST_IDLE) ? req_we : r_we;
  assign w_acc_misaligned = (r_state == ST_IDLE) ? (req_addr[1:0] != 2'b00) : r_misaligned;
  assign w_acc_idx        = (r_state == ST_IDLE) ? req_addr[AW+1:2] : r_idx;
  assign w_acc_wdata      = (r_state == ST_IDLE) ? req_wdata : r_wdata;

  assign w_mem_we     = w_enter_resp && w_acc_we && !w_acc_misaligned && !reset;
  assign w_resp_rdata = (!w_acc_we && !w_acc_misaligned) ? r_mem[w_acc_idx] : 32'd0;

  // Upper address bits are deliberately dropped so addresses wrap.
  assign w_unused_addr = ^req_addr[31:AW+2];

  // NOTE: the memory array has no reset branch; clearing it would force a
  // flop-based implementation and stored data must survive reset anyway.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_acc_idx] <= w_acc_wdata;
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 4'd0;
      r_we         <= 1'b0;
      r_misaligned <= 1'b0;
      r_idx        <= '0;
      r_wdata      <= 32'd0;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_rdata   <= 32'd0;
      resp_err     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_we         <= req_we;
            r_misaligned <= (req_addr[1:0] != 2'b00);
            r_idx        <= req_addr[AW+1:2];
            r_wdata      <= req_wdata;
            req_ready    <= 1'b0;
            if (WAIT > 0) begin
              r_state <= ST_WAIT;
              r_cnt   <= CNT_INIT;
            end else begin
              r_state    <= ST_RESP;
              resp_valid <= 1'b1;
              resp_rdata <= w_resp_rdata;
              resp_err   <= w_acc_misaligned;
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state    <= ST_RESP;
            resp_valid <= 1'b1;
            resp_rdata <= w_resp_rdata;
            resp_err   <= w_acc_misaligned;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          r_state    <= ST_IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_rdata <= 32'd0;
          resp_err   <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder at WAIT=2, DEPTH=64: latency, data,
// wrap-around, misalignment, held requests and reset mid-transaction.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_vec  = 0;
  int n_miss = 0;

  mem_responder #(.DEPTH(64), .WAIT(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One complete transaction with full latency checks: accept at edge N,
  // response high from N+2 to N+3, idle again after N+3.
  task automatic do_txn(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err);
    check({tag, "/ready_pre"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    step;  // edge N
    req_valid = 1'b0;
    check({tag, "/ready_N"}, 32'(req_ready), 32'd0);
    check({tag, "/valid_N"}, 32'(resp_valid), 32'd0);
    step;  // edge N+1
    check({tag, "/valid_N1"}, 32'(resp_valid), 32'd0);
    step;  // edge N+2
    check({tag, "/valid_N2"}, 32'(resp_valid), 32'd1);
    check({tag, "/rdata"}, resp_rdata, exp_rdata);
    check({tag, "/err"}, 32'(resp_err), 32'(exp_err));
    step;  // edge N+3
    check({tag, "/valid_N3"}, 32'(resp_valid), 32'd0);
    check({tag, "/rdata_idle"}, resp_rdata, 32'd0);
    check({tag, "/err_idle"}, 32'(resp_err), 32'd0);
    check({tag, "/ready_N3"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    #1;
    check("rst/valid", 32'(resp_valid), 32'd0);
    check("rst/rdata", resp_rdata, 32'd0);
    check("rst/err", 32'(resp_err), 32'd0);
    step;
    step;
    reset = 1'b0;
    step;
    check("rst/ready", 32'(req_ready), 32'd1);

    // Basic write then read-back.
    do_txn("wr10", 1'b1, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0);
    do_txn("rd10", 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);

    // 0x100 is word 64, which wraps onto word 0.
    do_txn("wr100", 1'b1, 32'h100, 32'h00001234, 32'd0, 1'b0);
    do_txn("rd0", 1'b0, 32'h0, 32'd0, 32'h00001234, 1'b0);

    // Misaligned read of the word holding 0xDEADBEEF returns 0 with error.
    do_txn("rd13", 1'b0, 32'h13, 32'd0, 32'd0, 1'b1);
    do_txn("wr20", 1'b1, 32'h20, 32'hCAFEF00D, 32'd0, 1'b0);
    do_txn("wr22", 1'b1, 32'h22, 32'hFFFFFFFF, 32'd0, 1'b1);
    do_txn("rd20", 1'b0, 32'h20, 32'd0, 32'hCAFEF00D, 1'b0);

    // Held request: only the address present at the next IDLE edge counts.
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h10;
    step;  // edge N, accepts 0x10
    req_addr = 32'h20;
    step;  // N+1
    step;  // N+2
    check("hold/valid1", 32'(resp_valid), 32'd1);
    check("hold/rdata1", resp_rdata, 32'hDEADBEEF);
    req_addr = 32'h0;
    step;  // N+3, back to IDLE
    check("hold/ready", 32'(req_ready), 32'd1);
    step;  // N+4, accepts 0x0
    req_valid = 1'b0;
    check("hold/ready_acc", 32'(req_ready), 32'd0);
    step;  // N+5
    check("hold/valid_gap", 32'(resp_valid), 32'd0);
    step;  // N+6
    check("hold/valid2", 32'(resp_valid), 32'd1);
    check("hold/rdata2", resp_rdata, 32'h00001234);
    step;  // N+7
    check("hold/valid_end", 32'(resp_valid), 32'd0);
    check("hold/ready_end", 32'(req_ready), 32'd1);

    // Reset during WAIT aborts the write.
    do_txn("wr30", 1'b1, 32'h30, 32'h0BADC0DE, 32'd0, 1'b0);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h30;
    req_wdata = 32'h5555AAAA;
    step;  // accept edge N
    req_valid = 1'b0;
    reset     = 1'b1;
    #1;
    check("rstw/valid_async", 32'(resp_valid), 32'd0);
    check("rstw/ready_async", 32'(req_ready), 32'd1);
    step;  // N+1
    step;  // N+2, where the response would have appeared
    check("rstw/valid_N2", 32'(resp_valid), 32'd0);
    reset = 1'b0;
    step;
    check("rstw/valid_post", 32'(resp_valid), 32'd0);
    check("rstw/ready_post", 32'(req_ready), 32'd1);
    do_txn("rd30", 1'b0, 32'h30, 32'd0, 32'h0BADC0DE, 1'b0);
    do_txn("rd10b", 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
